// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receive-side monitor for a multiplexed, active-low
// 7-segment display bus. It synchronizes the segment and anode buses, waits
// for each digit position to dwell stably for SETTLE cycles, decodes the
// segment pattern back to a digit code, and publishes a 32-bit frame once all
// eight positions have been captured.
//
// Optional feature: define SEG_CAPTURE_HEX_EN to also accept the hex glyphs
// A, b, C, d, E, F as valid digits. Without it those patterns count as errors.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   seg_n[6:0]   segment bus {CG..CA}, 0 = lit, asynchronous to clk
//   an_n[7:0]    anode bus {AN7..AN0}, 0 = enabled, asynchronous to clk
//   frame[31:0]  last complete frame, AN7 digit in [31:28] ... AN0 in [3:0]
//   frame_valid  one-cycle pulse when frame/frame_err are updated
//   frame_err    bit i set = slot i held an undecodable pattern
//   busy         high while a frame is partially captured
module seven_seg_capture #(
  parameter int unsigned SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [7:0]  an_n,
  output logic [31:0] frame,
  output logic        frame_valid,
  output logic [7:0]  frame_err,
  output logic        busy
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 8;
  localparam int unsigned SLOT_W  = 3;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned FRAME_W = AN_W * DIG_W;

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_M1  = CNT_W'(SETTLE - 1);

  // Two-flop synchronizers plus one-cycle history of the synced buses
  logic [SEG_W-1:0]   seg_s1, seg_s2, seg_p;
  logic [AN_W-1:0]    an_s1, an_s2, an_p;

  logic [CNT_W-1:0]   stable_cnt, cnt_next;
  logic               dwell_done, done_next;
  logic [AN_W-1:0]    mask, mask_next;
  logic [FRAME_W-1:0] digits, digits_next;
  logic [AN_W-1:0]    err, err_next;

  logic               stable_c;
  logic               capture_c;
  logic               complete_c;
  logic [SLOT_W-1:0]  slot_c;
  logic [DIG_W:0]     dec_c;

  // Segment pattern to {err, digit}; unknown patterns give {1, 4'hF}
  function automatic logic [DIG_W:0] decode(input logic [SEG_W-1:0] p);
    logic [DIG_W:0] r;
    r = {1'b1, 4'hF};
    case (p)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
`ifdef SEG_CAPTURE_HEX_EN
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
`endif
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // Dwell qualification: exactly one anode low and the whole bus unchanged
  always_comb begin
    stable_c   = $onehot(~an_s2) && ({an_s2, seg_s2} == {an_p, seg_p});
    capture_c  = stable_c && !dwell_done && (stable_cnt >= SETTLE_M1);
    complete_c = (mask == {AN_W{1'b1}});
    dec_c      = decode(seg_s2);
  end

  // Position of the enabled anode
  always_comb begin
    slot_c = '0;
    for (int i = 0; i < AN_W; i++) begin
      if (!an_s2[i]) slot_c = SLOT_W'(i);
    end
  end

  // Next-state for dwell counter, capture mask and digit/error registers
  always_comb begin
    cnt_next    = stable_cnt;
    done_next   = dwell_done;
    mask_next   = complete_c ? '0 : mask;
    digits_next = digits;
    err_next    = err;

    if (stable_c) begin
      if (stable_cnt < SETTLE_CNT) cnt_next = stable_cnt + CNT_W'(1);
      if (capture_c) done_next = 1'b1;
    end else begin
      cnt_next  = '0;
      done_next = 1'b0;
    end

    // A capture coinciding with frame completion seeds the next frame
    if (capture_c) begin
      mask_next[slot_c]                   = 1'b1;
      digits_next[{slot_c, 2'b00} +: DIG_W] = dec_c[DIG_W-1:0];
      err_next[slot_c]                    = dec_c[DIG_W];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_s1      <= '0;
      seg_s2      <= '0;
      seg_p       <= '0;
      an_s1       <= '0;
      an_s2       <= '0;
      an_p        <= '0;
      stable_cnt  <= '0;
      dwell_done  <= 1'b0;
      mask        <= '0;
      digits      <= '0;
      err         <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= '0;
      busy        <= 1'b0;
    end else begin
      seg_s1      <= seg_n;
      seg_s2      <= seg_s1;
      seg_p       <= seg_s2;
      an_s1       <= an_n;
      an_s2       <= an_s1;
      an_p        <= an_s2;
      stable_cnt  <= cnt_next;
      dwell_done  <= done_next;
      mask        <= mask_next;
      digits      <= digits_next;
      err         <= err_next;
      frame_valid <= complete_c;
      busy        <= |mask_next;
      if (complete_c) begin
        frame     <= digits;
        frame_err <= err;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: table of full-scan frames,
// hand-written multi-cycle corner cases, and a randomized dwell sequence
// checked against a dwell-level reference model.
module tb_seven_seg_capture;

  localparam int unsigned SETTLE = 16;
`ifdef SEG_CAPTURE_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [7:0]  an_n = 8'hFF;
  logic [31:0] frame;
  logic        frame_valid;
  logic [7:0]  frame_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  seven_seg_capture #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
    .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // Every frame_valid pulse is recorded for later comparison
  logic [31:0] got_f[$];
  logic [7:0]  got_e[$];
  always @(negedge clk) begin
    if (rst && frame_valid === 1'b1) begin
      got_f.push_back(frame);
      got_e.push_back(frame_err);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Reference decode: find the glyph whose drawing matches the pattern
  function automatic logic [4:0] model_dec(input logic [6:0] p);
    logic [4:0] r;
    r = {1'b1, 4'hF};
    for (int v = 0; v < 16; v++) begin
      if (seg_of(4'(v)) == p && (v < 10 || HEX)) r = {1'b0, 4'(v)};
    end
    return r;
  endfunction

  task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int d);
    an_n  = an;
    seg_n = seg;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hold(8'hFF, 7'h7F, 6);
  endtask

  // Show slots lo..hi in ascending order, blank[i] replaces slot i with all-off
  task automatic scan(input logic [31:0] dig, input logic [7:0] blank,
                      input int lo, input int hi, input int d);
    for (int i = lo; i <= hi; i++) begin
      hold(~(8'b1 << i), blank[i] ? 7'h7F : seg_of(dig[i*4 +: 4]), d);
    end
  endtask

  task automatic expect_one_frame(input string name, input logic [31:0] ef, input logic [7:0] ee);
    logic [31:0] f;
    logic [7:0]  e;
    f = (got_f.size() > 0) ? got_f[0] : 32'hxxxx_xxxx;
    e = (got_e.size() > 0) ? got_e[0] : 8'hxx;
    check({name, "_nframes"}, got_f.size(), 1);
    check({name, "_frame"}, f, ef);
    check({name, "_err"}, {24'h0, e}, {24'h0, ee});
    check({name, "_busy"}, {31'h0, busy}, 0);
    got_f.delete();
    got_e.delete();
  endtask

  task automatic expect_no_frame(input string name, input logic exp_busy);
    check({name, "_nframes"}, got_f.size(), 0);
    check({name, "_busy"}, {31'h0, busy}, {31'h0, exp_busy});
    got_f.delete();
    got_e.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] dig;
    logic [7:0]  blank;
    logic [31:0] exp_f;
    logic [7:0]  exp_e;
  } vec_t;

  // Dwell-level reference model state
  logic [3:0]  m_dig[8];
  bit          m_err[8];
  bit          m_seen[8];
  logic [31:0] exp_f[$];
  logic [7:0]  exp_e[$];

  function automatic bit model_busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < 8; i++) b |= m_seen[i];
    return b;
  endfunction

  // A dwell of d cycles on one anode is captured iff held SETTLE+1 cycles
  task automatic model_dwell(input logic [7:0] an, input logic [6:0] seg, input int d);
    int   slot;
    bit   all;
    logic [4:0]  r;
    logic [31:0] f;
    logic [7:0]  e;
    if ($countones(~an) != 1 || d < int'(SETTLE) + 1) return;
    slot = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) slot = i;
    r = model_dec(seg);
    m_dig[slot]  = r[3:0];
    m_err[slot]  = r[4];
    m_seen[slot] = 1'b1;
    all = 1'b1;
    for (int i = 0; i < 8; i++) all &= m_seen[i];
    if (all) begin
      for (int i = 0; i < 8; i++) begin
        f[i*4 +: 4] = m_dig[i];
        e[i]        = m_err[i];
        m_seen[i]   = 1'b0;
      end
      exp_f.push_back(f);
      exp_e.push_back(e);
    end
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{dig: 32'h1976_0319, blank: 8'h00, exp_f: 32'h1976_0319, exp_e: 8'h00};
    vt[1] = '{dig: 32'h1976_0319, blank: 8'h08, exp_f: 32'h1976_F319, exp_e: 8'h08};
    vt[2] = '{dig: 32'h1234_5678, blank: 8'h00, exp_f: 32'h1234_5678, exp_e: 8'h00};
`ifdef SEG_CAPTURE_HEX_EN
    vt[3] = '{dig: 32'hABCD_EF01, blank: 8'h00, exp_f: 32'hABCD_EF01, exp_e: 8'h00};
`else
    vt[3] = '{dig: 32'hABCD_EF01, blank: 8'h00, exp_f: 32'hFFFF_FF01, exp_e: 8'hFC};
`endif

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_frame", frame, 0);
    check("reset_valid", {31'h0, frame_valid}, 0);
    check("reset_err", {24'h0, frame_err}, 0);
    check("reset_busy", {31'h0, busy}, 0);
    @(posedge clk); #1;

    // Full scans from the table
    for (int k = 0; k < 4; k++) begin
      scan(vt[k].dig, vt[k].blank, 0, 7, 100);
      idle();
      expect_one_frame($sformatf("vec%0d", k), vt[k].exp_f, vt[k].exp_e);
    end

    // Short AN2 dwell is ignored until a full-length AN2 dwell arrives
    scan(32'h1976_0319, 8'h00, 0, 1, 100);
    scan(32'h1976_0319, 8'h00, 2, 2, 10);
    scan(32'h1976_0319, 8'h00, 3, 7, 100);
    idle();
    expect_no_frame("short_dwell", 1'b1);
    scan(32'h1976_0319, 8'h00, 2, 2, 100);
    idle();
    expect_one_frame("short_dwell_fill", 32'h1976_0319, 8'h00);

    // Exactly SETTLE synced cycles: no capture; SETTLE+1: capture
    scan(32'h1234_5678, 8'h00, 0, 6, 100);
    scan(32'h1234_5678, 8'h00, 7, 7, SETTLE);
    idle();
    expect_no_frame("dwell_settle", 1'b1);
    scan(32'h1234_5678, 8'h00, 7, 7, SETTLE + 1);
    idle();
    expect_one_frame("dwell_settle_p1", 32'h1234_5678, 8'h00);

    // Multiple anodes low, then blank bus: partial frame kept
    scan(32'h8765_4321, 8'h00, 0, 2, 100);
    hold(8'hFC, seg_of(4'h8), 100);
    expect_no_frame("multi_anode", 1'b1);
    hold(8'hFF, seg_of(4'h8), 100);
    expect_no_frame("blank_anode", 1'b1);
    scan(32'h8765_4321, 8'h00, 3, 7, 100);
    idle();
    expect_one_frame("partial_kept", 32'h8765_4321, 8'h00);

    // Reset mid-frame discards the partial capture
    scan(32'h1976_0319, 8'h00, 0, 4, 100);
    do_reset();
    #1;
    check("rst_mid_frame", frame, 0);
    expect_no_frame("rst_mid", 1'b0);
    scan(32'h1234_5678, 8'h00, 5, 7, 100);
    idle();
    expect_no_frame("rst_no_stale", 1'b1);
    scan(32'h1234_5678, 8'h00, 0, 4, 100);
    idle();
    expect_one_frame("rst_refill", 32'h1234_5678, 8'h00);

    // Randomized dwells against the reference model
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m_seen[i] = 1'b0;
      m_dig[i]  = 4'h0;
      m_err[i]  = 1'b0;
    end
    got_f.delete();
    got_e.delete();
    begin
      logic [7:0] an, pan;
      logic [6:0] seg, pseg;
      int d;
      pan  = 8'hFF;
      pseg = 7'h7F;
      for (int n = 0; n < 600; n++) begin
        do begin
          int r;
          r = int'($urandom_range(0, 99));
          if (r < 80)      an = ~(8'b1 << $urandom_range(0, 7));
          else if (r < 92) an = 8'($urandom);
          else             an = 8'hFF;
          if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
          else                           seg = seg_of(4'($urandom_range(0, 15)));
        end while ({an, seg} == {pan, pseg});
        case ($urandom_range(0, 5))
          0:       d = 3;
          1:       d = int'(SETTLE) - 1;
          2:       d = int'(SETTLE);
          3:       d = int'(SETTLE) + 1;
          4:       d = int'(SETTLE) + 2;
          default: d = int'($urandom_range(SETTLE + 8, 60));
        endcase
        model_dwell(an, seg, d);
        hold(an, seg, d);
        if (d >= int'(SETTLE) + 8)
          check($sformatf("rand_busy_%0d", n), {31'h0, busy}, {31'h0, model_busy()});
        pan  = an;
        pseg = seg;
      end
      hold(8'hFF, 7'h7F, 40);
    end
    check("rand_nframes", got_f.size(), exp_f.size());
    for (int i = 0; i < exp_f.size() && i < got_f.size(); i++) begin
      check($sformatf("rand_frame_%0d", i), got_f[i], exp_f[i]);
      check($sformatf("rand_err_%0d", i), {24'h0, got_e[i]}, {24'h0, exp_e[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
